// File: rtl/nmu_axis_pkg.sv
// Shared NMU AXI-Stream helpers: beat payload type, keep popcount and
// byte-counter width derivation. No ports.
package nmu_axis_pkg;

    // Largest bus configuration the shared beat type can carry.
    localparam int unsigned MAX_BUS_W  = 512;
    localparam int unsigned MAX_KEEP_W = MAX_BUS_W / 8;
    localparam int unsigned MAX_ID_W   = 8;
    localparam int unsigned KEEP_CNT_W = $clog2(MAX_KEEP_W + 1);

    // One buffered egress beat; unused high bits stay zero and are pruned.
    typedef struct packed {
        logic [MAX_BUS_W-1:0]  tdata;
        logic [MAX_KEEP_W-1:0] tkeep;
        logic                  tlast;
        logic                  tuser;
        logic [MAX_ID_W-1:0]   tid;
    } axis_beat_t;

    // Number of enabled bytes in a beat.
    function automatic logic [KEEP_CNT_W-1:0] popcount(input logic [MAX_KEEP_W-1:0] keep);
        logic [KEEP_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(MAX_KEEP_W); i++) begin
            n = n + KEEP_CNT_W'(keep[i]);
        end
        return n;
    endfunction

    // Byte counter width: one spare bit above the legal range so overflow is visible.
    function automatic int unsigned byte_cnt_width(input int unsigned max_len);
        return $clog2(max_len + 1) + 1;
    endfunction

endpackage

// File: rtl/egr_tuser_insert_if.sv
// AXI-Stream bundle used on both sides of egr_tuser_insert.
// Signals: tdata, tkeep, tlast, tvalid, tready, tuser, tid, tdest.
// master drives everything except tready; slave drives only tready.
interface egr_tuser_insert_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEST_W = 4
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;
    logic                tuser;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;

    modport master (output tdata, tkeep, tlast, tvalid, tuser, tid, tdest, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, tuser, tid, tdest, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: 1-cycle latency, full throughput,
// registered s_ready_o (high while fewer than two entries are held).
// Ports: clk, rst_n (async active-low), s_valid_i/s_ready_o/s_data_i upstream,
// m_valid_o/m_ready_i/m_data_o downstream.
module axis_skid_buffer #(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [PAYLOAD_W-1:0] s_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [PAYLOAD_W-1:0] m_data_o
);
    logic [PAYLOAD_W-1:0] head_q, head_d, skid_q, skid_d;
    logic                 head_v_q, head_v_d, skid_v_q, skid_v_d;
    logic                 ready_q, ready_d;
    logic                 push, pop;

    // Head register feeds the output; skid holds the second entry while stalled.
    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        push     = s_valid_i & ready_q;
        pop      = head_v_q & m_ready_i;
        if (!head_v_q || pop) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                head_v_d = 1'b1;
                skid_v_d = push;
                if (push) skid_d = s_data_i;
            end else begin
                head_v_d = push;
                if (push) head_d = s_data_i;
            end
        end else if (push) begin
            skid_d   = s_data_i;
            skid_v_d = 1'b1;
        end
        ready_d = !(head_v_d && skid_v_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            head_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            head_v_q <= head_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = head_v_q;
    assign m_data_o  = head_q;

endmodule

// File: rtl/egr_tuser_insert.sv
// Egress tuser insertion: moves the source VF ID from tdest to tid, drives a
// fixed egress tdest and flags bad packets on tuser of the tlast beat
// (over-length, ID change mid-packet, empty tlast beat).
// Ports: aclk, aresetn (async active-low), axis_in (slave side of the VF
// stream, tdest = VF ID), axis_out (master side, registered via skid buffer).
module egr_tuser_insert
    import nmu_axis_pkg::*;
#(
    parameter int unsigned AXIS_BUS_WIDTH    = 64,
    parameter int unsigned AXIS_ID_WIDTH     = 4,
    parameter int unsigned MAX_PACKET_LENGTH = 1522,
    parameter int unsigned EGRESS_DEST       = 0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    egr_tuser_insert_if.slave    axis_in,
    egr_tuser_insert_if.master   axis_out
);
    localparam int unsigned ID_W   = (AXIS_ID_WIDTH == 0) ? 1 : AXIS_ID_WIDTH;
    localparam int unsigned DEST_W = AXIS_ID_WIDTH + 1;
    localparam int unsigned CNT_W  = byte_cnt_width(MAX_PACKET_LENGTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             in_packet_q, in_packet_d;
    logic [ID_W-1:0]  pkt_id_q, pkt_id_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             id_err_q, id_err_d;
    logic             len_err_q, len_err_d;

    logic             s_ready, m_valid, in_fire;
    logic [ID_W-1:0]  cur_id_c, beat_id_c;
    logic [31:0]      sum_w_c;
    logic [CNT_W-1:0] cnt_sat_c;
    logic             id_err_nx_c, len_err_nx_c, zero_keep_c;
    axis_beat_t       in_beat, m_beat;
    logic             unused_ok;

    assign in_fire = axis_in.tvalid & s_ready;

    // Per-beat tracking and beat assembly.
    always_comb begin
        in_packet_d  = in_packet_q;
        pkt_id_d     = pkt_id_q;
        byte_cnt_d   = byte_cnt_q;
        id_err_d     = id_err_q;
        len_err_d    = len_err_q;
        in_beat      = '0;

        cur_id_c     = (AXIS_ID_WIDTH == 0) ? '0 : axis_in.tdest;
        beat_id_c    = in_packet_q ? pkt_id_q : cur_id_c;
        // 32-bit sum keeps the saturation test correct for any counter width.
        sum_w_c      = 32'(in_packet_q ? byte_cnt_q : '0)
                     + 32'(popcount(MAX_KEEP_W'(axis_in.tkeep)));
        cnt_sat_c    = (sum_w_c > 32'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum_w_c);
        id_err_nx_c  = id_err_q | (in_packet_q && (cur_id_c != pkt_id_q));
        len_err_nx_c = len_err_q | (sum_w_c > 32'(MAX_PACKET_LENGTH));
        zero_keep_c  = (axis_in.tkeep == '0);

        in_beat.tdata = MAX_BUS_W'(axis_in.tdata);
        in_beat.tkeep = MAX_KEEP_W'(axis_in.tkeep);
        in_beat.tlast = axis_in.tlast;
        in_beat.tuser = axis_in.tlast & (len_err_nx_c | id_err_nx_c | zero_keep_c);
        in_beat.tid   = MAX_ID_W'(beat_id_c);

        if (in_fire) begin
            if (axis_in.tlast) begin
                in_packet_d = 1'b0;
                byte_cnt_d  = '0;
                id_err_d    = 1'b0;
                len_err_d   = 1'b0;
            end else begin
                in_packet_d = 1'b1;
                pkt_id_d    = beat_id_c;
                byte_cnt_d  = cnt_sat_c;
                id_err_d    = id_err_nx_c;
                len_err_d   = len_err_nx_c;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_packet_q <= 1'b0;
            pkt_id_q    <= '0;
            byte_cnt_q  <= '0;
            id_err_q    <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            in_packet_q <= in_packet_d;
            pkt_id_q    <= pkt_id_d;
            byte_cnt_q  <= byte_cnt_d;
            id_err_q    <= id_err_d;
            len_err_q   <= len_err_d;
        end
    end

    axis_skid_buffer #(
        .PAYLOAD_W ($bits(axis_beat_t))
    ) u_skid (
        .clk       (aclk),
        .rst_n     (aresetn),
        .s_valid_i (axis_in.tvalid),
        .s_ready_o (s_ready),
        .s_data_i  (in_beat),
        .m_valid_o (m_valid),
        .m_ready_i (axis_out.tready),
        .m_data_o  (m_beat)
    );

    assign axis_in.tready  = s_ready;
    assign axis_out.tvalid = m_valid;
    assign axis_out.tdata  = AXIS_BUS_WIDTH'(m_beat.tdata);
    assign axis_out.tkeep  = (AXIS_BUS_WIDTH / 8)'(m_beat.tkeep);
    assign axis_out.tlast  = m_beat.tlast;
    assign axis_out.tuser  = m_beat.tuser;
    assign axis_out.tid    = ID_W'(m_beat.tid);
    assign axis_out.tdest  = DEST_W'(EGRESS_DEST);

    // Input-side tid/tuser are not meaningful; padding bits of the beat are constant.
    assign unused_ok = ^{axis_in.tid, axis_in.tuser, m_beat};

endmodule

// File: tb/tb_egr_tuser_insert.sv
// Directed self-checking bench for egr_tuser_insert (MAX_PACKET_LENGTH=64,
// EGRESS_DEST=3). Inputs change and outputs are sampled 1 ns after posedge.
module tb_egr_tuser_insert;
    localparam int unsigned BW   = 64;
    localparam int unsigned IDW  = 4;
    localparam int unsigned MAXL = 64;
    localparam int unsigned EDST = 3;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    egr_tuser_insert_if #(.DATA_W(BW), .ID_W(IDW), .DEST_W(IDW))     in_if ();
    egr_tuser_insert_if #(.DATA_W(BW), .ID_W(IDW), .DEST_W(IDW + 1)) out_if ();

    egr_tuser_insert #(
        .AXIS_BUS_WIDTH    (BW),
        .AXIS_ID_WIDTH     (IDW),
        .MAX_PACKET_LENGTH (MAXL),
        .EGRESS_DEST       (EDST)
    ) dut (
        .aclk     (clk),
        .aresetn  (rst_n),
        .axis_in  (in_if.slave),
        .axis_out (out_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [63:0] d;
        logic [3:0]  dest;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  tid;
        logic        user;
    } vec_t;

    task automatic drive(input logic v, input logic [63:0] d, input logic [3:0] dest,
                         input logic [7:0] keep, input logic last);
        in_if.tvalid = v;
        in_if.tdata  = d;
        in_if.tdest  = dest;
        in_if.tkeep  = keep;
        in_if.tlast  = last;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [63:0] d, input logic [3:0] id,
                            input logic [7:0] keep, input logic last, input logic user);
        chk({tag, ".tvalid"}, 64'(out_if.tvalid), 64'd1);
        chk({tag, ".tdata"},  out_if.tdata, d);
        chk({tag, ".tid"},    64'(out_if.tid), 64'(id));
        chk({tag, ".tdest"},  64'(out_if.tdest), 64'(EDST));
        chk({tag, ".tkeep"},  64'(out_if.tkeep), 64'(keep));
        chk({tag, ".tlast"},  64'(out_if.tlast), 64'(last));
        chk({tag, ".tuser"},  64'(out_if.tuser), 64'(user));
    endtask

    vec_t v4 [4];
    int   nin, nout, occ;
    logic ordy, push, pop;

    initial begin
        drive(1'b0, 64'h0, 4'h0, 8'h00, 1'b0);
        in_if.tid    = '0;
        in_if.tuser  = 1'b0;
        out_if.tready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick;

        // Reset state and ready rising one edge after release.
        chk("rst.tvalid", 64'(out_if.tvalid), 64'd0);
        chk("rst.tready", 64'(in_if.tready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.ready_before_edge", 64'(in_if.tready), 64'd0);
        tick;
        chk("rst.ready_after_edge", 64'(in_if.tready), 64'd1);

        // 3-beat packet, ID 5, 20 bytes: clean, 1-cycle latency, no bubbles.
        drive(1'b1, 64'h1111_0001, 4'd5, 8'hFF, 1'b0); tick;
        chk_beat("t1.b0", 64'h1111_0001, 4'd5, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 64'h1111_0002, 4'd5, 8'hFF, 1'b0); tick;
        chk_beat("t1.b1", 64'h1111_0002, 4'd5, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 64'h1111_0003, 4'd5, 8'h0F, 1'b1); tick;
        chk_beat("t1.b2", 64'h1111_0003, 4'd5, 8'h0F, 1'b1, 1'b0);
        drive(1'b0, 64'h0, 4'h0, 8'h00, 1'b0); tick;
        chk("t1.idle", 64'(out_if.tvalid), 64'd0);

        // 9 full beats = 72 B > 64: error only on the tlast beat.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 64'hA000 + 64'(i), 4'd2, 8'hFF, i == 8); tick;
            chk_beat($sformatf("t2.b%0d", i), 64'hA000 + 64'(i), 4'd2, 8'hFF, i == 8, i == 8);
        end
        drive(1'b1, 64'hB0, 4'd4, 8'hFF, 1'b1); tick;
        chk_beat("t2.next", 64'hB0, 4'd4, 8'hFF, 1'b1, 1'b0);

        // ID change mid-packet: tid held at 3, error on last beat.
        drive(1'b1, 64'hC1, 4'd3, 8'hFF, 1'b0); tick;
        chk_beat("t3.b0", 64'hC1, 4'd3, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 64'hC2, 4'd7, 8'hFF, 1'b1); tick;
        chk_beat("t3.b1", 64'hC2, 4'd3, 8'hFF, 1'b1, 1'b1);

        // Empty tlast beat flagged.
        drive(1'b1, 64'hD1, 4'd1, 8'h00, 1'b1); tick;
        chk_beat("t5.zk", 64'hD1, 4'd1, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 64'h0, 4'h0, 8'h00, 1'b0); tick;
        chk("t5.idle", 64'(out_if.tvalid), 64'd0);

        // Back-to-back packets with output ready pattern 1,0,0,1.
        v4[0] = '{64'hE0, 4'd6, 8'hFF, 1'b0, 4'd6, 1'b0};
        v4[1] = '{64'hE1, 4'd6, 8'hFF, 1'b1, 4'd6, 1'b0};
        v4[2] = '{64'hE2, 4'd8, 8'hFF, 1'b0, 4'd8, 1'b0};
        v4[3] = '{64'hE3, 4'd9, 8'h3F, 1'b1, 4'd8, 1'b1};
        nin = 0; nout = 0; occ = 0;
        for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
            ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            out_if.tready = ordy;
            chk($sformatf("t4.c%0d.in_ready", cyc), 64'(in_if.tready), 64'(occ < 2));
            chk($sformatf("t4.c%0d.out_valid", cyc), 64'(out_if.tvalid), 64'(occ > 0));
            if (occ > 0)
                chk_beat($sformatf("t4.c%0d", cyc), v4[nout].d, v4[nout].tid,
                         v4[nout].keep, v4[nout].last, v4[nout].user);
            push = (nin < 4) && (occ < 2);
            pop  = (occ > 0) && ordy;
            if (nin < 4) drive(1'b1, v4[nin].d, v4[nin].dest, v4[nin].keep, v4[nin].last);
            else         drive(1'b0, 64'h0, 4'h0, 8'h00, 1'b0);
            tick;
            nin  = nin + int'(push);
            nout = nout + int'(pop);
            occ  = occ + int'(push) - int'(pop);
        end
        chk("t4.all_out", 64'(nout), 64'd4);
        drive(1'b0, 64'h0, 4'h0, 8'h00, 1'b0);
        out_if.tready = 1'b1;
        tick;
        chk("t4.drained", 64'(out_if.tvalid), 64'd0);

        // Reset after beat 2 of a 4-beat packet; fresh packet afterwards.
        drive(1'b1, 64'hF0, 4'd2, 8'hFF, 1'b0); tick;
        chk_beat("t6.b0", 64'hF0, 4'd2, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 64'hF1, 4'd2, 8'hFF, 1'b0); tick;
        chk_beat("t6.b1", 64'hF1, 4'd2, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 64'hF2, 4'd2, 8'hFF, 1'b0);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 64'h0, 4'h0, 8'h00, 1'b0);
        #1;
        chk("t6.rst_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("t6.rst_tready", 64'(in_if.tready), 64'd0);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        chk("t6.ready_back", 64'(in_if.tready), 64'd1);
        // 8 full beats = exactly 64 B: clean only if the count restarted.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h9000 + 64'(i), 4'd9, 8'hFF, i == 7); tick;
            chk_beat($sformatf("t6.p%0d", i), 64'h9000 + 64'(i), 4'd9, 8'hFF, i == 7, 1'b0);
        end
        drive(1'b0, 64'h0, 4'h0, 8'h00, 1'b0); tick;
        chk("t6.idle", 64'(out_if.tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
